// File: rtl/conv_output_framer.sv
// rtl/conv_output_framer.sv - keeps valid convolution results, tags sof/eol/eof, buffers them in a ready/valid FIFO
module conv_output_framer #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int NUM_ROWS   = 540,
  parameter int KERNEL_DIM = 3,
  parameter int LATENCY    = 2*ROW_SIZE+7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int LW = $clog2(LATENCY + 1);
  localparam int EW = WORD_SIZE + 3;

  localparam logic [CW-1:0] COL_LAST  = CW'(ROW_SIZE - 1);
  localparam logic [CW-1:0] COL_KEEP  = CW'(ROW_SIZE - KERNEL_DIM);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_ROWS - KERNEL_DIM);
  localparam logic [LW-1:0] SKIP_LAST = LW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, SKIP, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   skip_cnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   head;

  logic fifo_empty, fifo_full;
  logic start_ok, keep, push_req, push, pop, drop, stream_end;
  logic sof, eol, eof;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign start_ok   = (state == IDLE) && start;
  assign keep       = (col <= COL_KEEP);
  assign push_req   = (state == STREAM) && keep;
  assign pop        = !fifo_empty && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign stream_end = (state == STREAM) && (col == COL_LAST) && (row == ROW_LAST);

  assign sof = (row == '0) && (col == '0);
  assign eol = (col == COL_KEEP);
  assign eof = eol && (row == ROW_LAST);

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = SKIP;
      SKIP:   if (skip_cnt == SKIP_LAST) state_nxt = STREAM;
      STREAM: if (stream_end) state_nxt = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // skip_cnt holds the current cycle number since start; the start cycle itself is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= '0;
      col      <= '0;
      row      <= '0;
    end else if (start_ok) begin
      skip_cnt <= LW'(1);
      col      <= '0;
      row      <= '0;
    end else if (state == SKIP) begin
      skip_cnt <= skip_cnt + LW'(1);
    end else if (state == STREAM) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (start_ok) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {eof, eol, sof, in_pixel};
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !fifo_empty;
  assign out_pixel = out_valid ? head[WORD_SIZE-1:0] : '0;
  assign out_sof   = out_valid & head[WORD_SIZE];
  assign out_eol   = out_valid & head[WORD_SIZE+1];
  assign out_eof   = out_valid & head[WORD_SIZE+2];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_conv_output_framer.sv
// tb/tb_conv_output_framer.sv - randomized and directed bench for conv_output_framer with a queue-based reference model
module tb_conv_output_framer;

  localparam int W    = 8;
  localparam int ROW  = 6;
  localparam int NR   = 5;
  localparam int K    = 3;
  localparam int LAT  = 4;
  localparam int DEP  = 4;
  localparam int SLEN = ROW * (NR - K + 1);

  logic         clk, rst_n, start, out_ready;
  logic [W-1:0] in_pixel, out_pixel;
  logic         out_valid, out_sof, out_eol, out_eof, busy, frame_done, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame timeline plus a bounded queue of {eof,eol,sof,pixel}.
  logic [W+2:0] mq[$];
  logic [W+2:0] acc[$];
  int           m_phase = 0;   // 0 idle, 1 skip/stream, 2 drain
  int           m_k = 0;       // cycle index of the next edge, start cycle = 0
  bit           m_ovf = 0;
  int           m_pre, m_i, m_c, m_r;
  bit           m_pop, m_sof, m_eol, m_eof;
  int           done_cnt = 0;
  int           pix_n = 0;
  bit           count_mode = 1;

  conv_output_framer #(
    .WORD_SIZE(W), .ROW_SIZE(ROW), .NUM_ROWS(NR), .KERNEL_DIM(K),
    .LATENCY(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_pixel(in_pixel),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_phase = 0;
        m_k     = 0;
        m_ovf   = 0;
      end else begin
        m_pre = mq.size();
        m_pop = (m_pre > 0) && out_ready;
        if (m_pop) begin
          acc.push_back(mq[0]);
          void'(mq.pop_front());
        end
        case (m_phase)
          0: if (start) begin
            m_phase = 1;
            m_k     = 1;
            m_ovf   = 0;
          end
          1: begin
            if (m_k >= LAT) begin
              m_i = m_k - LAT;
              m_c = m_i % ROW;
              m_r = m_i / ROW;
              if (m_c <= ROW - K) begin
                m_sof = (m_r == 0) && (m_c == 0);
                m_eol = (m_c == ROW - K);
                m_eof = m_eol && (m_r == NR - K);
                if (m_pre < DEP || m_pop) mq.push_back({m_eof, m_eol, m_sof, in_pixel});
                else m_ovf = 1;
              end
              if (m_i == SLEN - 1) m_phase = 2;
            end
            m_k++;
          end
          default: if (m_pre == 0) m_phase = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0)
        check("head", 32'({out_eof, out_eol, out_sof, out_pixel}), 32'(mq[0]));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("frame_done", 32'(frame_done), 32'(m_phase == 2 && mq.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (frame_done) done_cnt++;
    end
  end

  function automatic logic will_push();
    return (m_phase == 1) && (m_k >= LAT) && (((m_k - LAT) % ROW) <= ROW - K);
  endfunction

  // 0: always ready, 1: random, 2: hold FIFO full and pop only on push cycles, 3: stall until drain
  function automatic logic next_ready(input int mode);
    case (mode)
      0: return 1'b1;
      1: return 1'($urandom_range(0, 1));
      2: return (m_phase == 2) ? 1'b1 : ((mq.size() < DEP) ? 1'b0 : will_push());
      default: return (m_phase == 2);
    endcase
  endfunction

  task automatic cyc(input logic st, input logic rdy);
    if (st && m_phase == 0) pix_n = 0;
    start     = st;
    out_ready = rdy;
    in_pixel  = count_mode ? W'(pix_n) : W'($urandom);
    @(posedge clk);
    #2;
    pix_n++;
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input int mode, input bit spur, input bit spur_rand);
    int  n;
    logic st;
    n = 0;
    cyc(1'b1, next_ready(mode));
    while (m_phase != 0 && n < 300) begin
      st = (spur && m_phase == 1 && m_k == 2) || (spur && m_phase == 2) ||
           (spur_rand && $urandom_range(0, 7) == 0);
      cyc(st, next_ready(mode));
      n++;
    end
    n_tests++;
    if (m_phase != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: frame still active after %0d cycles", name, n);
    end
  endtask

  task automatic check_frame(input string name, input int n_exp);
    int ev[12] = '{4, 5, 6, 7, 10, 11, 12, 13, 16, 17, 18, 19};
    logic [W+2:0] e;
    check({name, "_count"}, 32'(acc.size()), 32'(n_exp));
    for (int j = 0; j < n_exp && j < acc.size(); j++) begin
      e = {(j == 11), (j % 4 == 3), (j == 0), W'(ev[j])};
      check($sformatf("%s_px%0d", name, j), 32'(acc[j]), 32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, n;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pixel", 32'(out_pixel), 0);
    check("rst_flags", 32'({out_sof, out_eol, out_eof}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    #1 rst_n = 1'b1;

    // free flow
    acc.delete(); d0 = done_cnt;
    run_frame("s1", 0, 0, 0);
    check_frame("s1", 12);
    check("s1_done_cnt", 32'(done_cnt - d0), 1);
    check("s1_ovf", 32'(overflow), 0);

    // stalled through STREAM
    acc.delete(); d0 = done_cnt;
    run_frame("s2", 3, 0, 0);
    check_frame("s2", 4);
    check("s2_ovf", 32'(overflow), 1);
    check("s2_done_cnt", 32'(done_cnt - d0), 1);

    // full FIFO with pops on push cycles
    acc.delete();
    run_frame("s3", 2, 0, 0);
    check_frame("s3", 12);
    check("s3_ovf", 32'(overflow), 0);

    // reset in the middle of STREAM
    acc.delete();
    cyc(1'b1, 1'b1);
    n = 0;
    while (!(m_phase == 1 && m_k >= LAT + 5) && n < 50) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    rst_n = 1'b0;
    #1;
    check("s4_rst_valid", 32'(out_valid), 0);
    check("s4_rst_busy", 32'(busy), 0);
    check("s4_rst_ovf", 32'(overflow), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    acc.delete();
    run_frame("s4", 0, 0, 0);
    check_frame("s4", 12);

    // spurious starts in SKIP and DRAIN
    acc.delete();
    run_frame("s5", 0, 1, 0);
    check_frame("s5", 12);
    check("s5_idle_busy", 32'(busy), 0);

    // back-to-back: overflowed frame then a start the cycle after frame_done
    acc.delete();
    run_frame("s6a", 3, 0, 0);
    check("s6a_ovf", 32'(overflow), 1);
    acc.delete();
    run_frame("s6b", 0, 0, 0);
    check_frame("s6b", 12);
    check("s6b_ovf", 32'(overflow), 0);

    // random pixels, random backpressure, random stray starts
    count_mode = 0;
    repeat (6) begin
      acc.delete();
      run_frame("rnd", 1, 0, 1);
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
